// File: rtl/rom_fetch_unit.sv
// Instruction fetch unit streaming 32-bit words from a combinational ROM into a
// one-entry valid/ready output register, with branch redirect and halt-word stop.
module rom_fetch_unit #(
  parameter logic [31:0] HALT_WORD     = 32'h0000_0000,
  parameter logic [15:0] START_DEFAULT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic [15:0] addressROM,
  input  logic [31:0] outROM,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [31:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_valid;
  logic        r_halted;

  logic [15:0] w_pc_next;
  logic        w_valid_next;
  logic        w_load;
  logic        w_is_halt;

  assign w_is_halt = (outROM == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: begin
        if (branch_valid)            w_next_state = S_FETCH;
        else if (w_load && w_is_halt) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (branch_valid)     w_next_state = S_FETCH;
        else if (instr_ready) w_next_state = S_HALT;
      end
      S_HALT:  if (start) w_next_state = S_FETCH;
      default: w_next_state = S_IDLE;
    endcase
  end

  // A branch always wins over a load and flushes the presented word.
  always_comb begin
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_valid_next = 1'b0;
        if (start) w_pc_next = start_addr;
      end
      S_FETCH: begin
        if (branch_valid) begin
          w_pc_next    = branch_target;
          w_valid_next = 1'b0;
        end else if (!r_valid || instr_ready) begin
          w_load       = 1'b1;
          w_valid_next = 1'b1;
          if (!w_is_halt) w_pc_next = r_pc + 16'd1;
        end
      end
      S_DRAIN: begin
        if (branch_valid) begin
          w_pc_next    = branch_target;
          w_valid_next = 1'b0;
        end else if (instr_ready) begin
          w_valid_next = 1'b0;
        end
      end
      default: w_valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= START_DEFAULT;
      r_instr    <= 32'h0;
      r_instr_pc <= 16'h0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_valid  <= w_valid_next;
      r_halted <= (w_next_state == S_HALT);
      if (w_load) begin
        r_instr    <= outROM;
        r_instr_pc <= r_pc;
      end
    end
  end

  assign addressROM  = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: streaming, backpressure, branch, wrap,
// async reset and restart, against hand-computed expected values.
module tb_rom_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic [15:0] addressROM;
  logic [31:0] outROM;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  int n_checks;
  int n_fail;

  rom_fetch_unit #(
    .HALT_WORD    (32'h0000_0000),
    .START_DEFAULT(16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .addressROM   (addressROM),
    .outROM       (outROM),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .halted       (halted)
  );

  // ROM contents: 0x100+addr everywhere, halt word (0) at address 8.
  always_comb begin
    if (addressROM == 16'd8) outROM = 32'h0000_0000;
    else                     outROM = 32'h100 + {16'h0, addressROM};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    start = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    start = 1'b0;
    start_addr = 16'h0;
    branch_valid = 1'b0;
    branch_target = 16'h0;
    instr_ready = 1'b0;

    // Reset takes effect without a clock edge
    #12 rst_n = 1'b0;
    #1;
    chk_eq("rst_addr",  addressROM, 32'h0);
    chk_eq("rst_valid", instr_valid, 32'h0);
    chk_eq("rst_instr", instr, 32'h0);
    chk_eq("rst_ipc",   instr_pc, 32'h0);
    chk_eq("rst_halt",  halted, 32'h0);
    #10 rst_n = 1'b1;
    tick(); tick();
    branch_valid = 1'b1; branch_target = 16'h0033;
    tick();
    branch_valid = 1'b0;
    chk_eq("idle_ign_br", addressROM, 32'h0);
    chk_eq("idle_valid",  instr_valid, 32'h0);

    // Streaming to the halt word
    start = 1'b1; start_addr = 16'h0000; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk_eq("st_addr0", addressROM, 32'h0);
    chk_eq("st_valid0", instr_valid, 32'h0);
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk_eq("st_valid", instr_valid, 32'h1);
      chk_eq("st_ipc", instr_pc, k);
      chk_eq("st_instr", instr, (k == 8) ? 32'h0 : 32'h100 + k);
    end
    chk_eq("st_nohalt", halted, 32'h0);
    chk_eq("st_addr8", addressROM, 32'h8);
    tick();
    chk_eq("st_halted", halted, 32'h1);
    chk_eq("st_hvalid", instr_valid, 32'h0);
    chk_eq("st_haddr", addressROM, 32'h8);
    branch_valid = 1'b1; branch_target = 16'h0055;
    tick();
    branch_valid = 1'b0;
    chk_eq("halt_ign_br", addressROM, 32'h8);
    chk_eq("halt_stay", halted, 32'h1);

    // Restart from HALT
    start = 1'b1; start_addr = 16'h0010;
    tick();
    start = 1'b0;
    chk_eq("rs_halted", halted, 32'h0);
    chk_eq("rs_addr", addressROM, 32'h10);
    chk_eq("rs_valid0", instr_valid, 32'h0);
    tick();
    chk_eq("rs_valid", instr_valid, 32'h1);
    chk_eq("rs_ipc", instr_pc, 32'h10);
    chk_eq("rs_instr", instr, 32'h110);

    // Backpressure on word @2
    do_reset();
    start = 1'b1; start_addr = 16'h0000; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_eq("bp_ipc2", instr_pc, 32'h2);
    instr_ready = 1'b0;
    start = 1'b1; start_addr = 16'h0077;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("bp_instr", instr, 32'h102);
      chk_eq("bp_addr", addressROM, 32'h3);
      chk_eq("bp_valid", instr_valid, 32'h1);
    end
    start = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk_eq("bp_rel_instr", instr, 32'h103);
    chk_eq("bp_rel_ipc", instr_pc, 32'h3);
    tick();
    chk_eq("bp_w4_ipc", instr_pc, 32'h4);

    // Branch while word @4 stalled
    instr_ready = 1'b0;
    branch_valid = 1'b1; branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    chk_eq("br_valid", instr_valid, 32'h0);
    chk_eq("br_addr", addressROM, 32'h40);
    chk_eq("br_instr_hold", instr, 32'h104);
    tick();
    chk_eq("br_nvalid", instr_valid, 32'h1);
    chk_eq("br_ipc", instr_pc, 32'h40);
    chk_eq("br_instr", instr, 32'h140);

    // Address wrap
    do_reset();
    start = 1'b1; start_addr = 16'hFFFE; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_eq("wr_ipc0", instr_pc, 32'hFFFE);
    chk_eq("wr_ins0", instr, 32'h100FE);
    tick();
    chk_eq("wr_ipc1", instr_pc, 32'hFFFF);
    tick();
    chk_eq("wr_ipc2", instr_pc, 32'h0000);
    chk_eq("wr_ins2", instr, 32'h100);
    tick();
    chk_eq("wr_ipc3", instr_pc, 32'h0001);

    // Async reset pulse mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk_eq("ar_valid", instr_valid, 32'h0);
    chk_eq("ar_addr", addressROM, 32'h0);
    #2 rst_n = 1'b1;
    tick(); tick();
    chk_eq("ar_idle_valid", instr_valid, 32'h0);
    chk_eq("ar_idle_addr", addressROM, 32'h0);
    chk_eq("ar_idle_halt", halted, 32'h0);
    start = 1'b1; start_addr = 16'h0005;
    tick();
    start = 1'b0;
    tick();
    chk_eq("ar_rs_ipc", instr_pc, 32'h5);
    chk_eq("ar_rs_instr", instr, 32'h105);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

Interface
REQ-001 The module SHALL have parameter HALT_WORD, default 32'h0000_0000, meaning the instruction word that ends fetching.
REQ-002 The module SHALL have parameter START_DEFAULT, default 16'h0000, meaning the pc value after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin fetching from start_addr.
REQ-006 start_addr  input  16  first fetch address.
REQ-007 branch_valid  input  1  redirect fetch this cycle.
REQ-008 branch_target  input  16  redirect address.
REQ-009 addressROM  output  16  ROM address, driven directly from the pc register.
REQ-010 outROM  input  32  ROM data for addressROM, combinational and valid in the same cycle.
REQ-011 instr  output  32  registered instruction word.
REQ-012 instr_pc  output  16  address the instr word was fetched from.
REQ-013 instr_valid  output  1  instr/instr_pc hold a word not yet consumed.
REQ-014 instr_ready  input  1  consumer accepts the word when instr_valid && instr_ready.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DRAIN and HALT.
REQ-017 IDLE: start=1 -> pc<=start_addr, go to FETCH; all other inputs ignored.
REQ-018 FETCH load condition: load = !instr_valid || instr_ready.
REQ-019 On a load, the block SHALL do all of: instr<=outROM; instr_pc<=pc; instr_valid<=1; pc<=pc+1, 16-bit wrap with 16'hFFFF -> 16'h0000.
REQ-020 In FETCH with no load, the block SHALL hold pc, instr, instr_pc and instr_valid (stall).
REQ-021 In FETCH with a consume and a load in the same cycle, instr_valid SHALL stay 1; sustained throughput SHALL be one word per cycle.
REQ-022 If the loaded word equals HALT_WORD, the word SHALL still be presented, pc SHALL NOT increment, and the FSM SHALL go to DRAIN.
REQ-023 DRAIN: no loads; on consume, instr_valid<=0 and go to HALT.
REQ-024 HALT: halted=1, instr_valid=0.
REQ-025 HALT: start=1 -> pc<=start_addr, go to FETCH.
REQ-026 Branch in FETCH or DRAIN: branch_valid=1 SHALL set pc<=branch_target and instr_valid<=0 (the word is flushed even if instr_ready=1).
REQ-027 A branch SHALL suppress any load that cycle and leave the FSM in FETCH.
REQ-028 branch_valid SHALL be ignored in IDLE and HALT.
REQ-029 start SHALL be ignored in FETCH and DRAIN.
REQ-030 If start and branch_valid are both high, the FSM state selects which one applies; they SHALL never both act in one cycle.
REQ-031 Latency: start sampled at edge N -> addressROM=start_addr after edge N -> instr_valid=1 with instr=ROM[start_addr] after edge N+1.
REQ-032 Branch latency SHALL be the same: the first redirected word is valid two edges after branch_valid is sampled.
REQ-033 halted SHALL be registered and equal (state==HALT).
REQ-034 instr and instr_pc SHALL change only on a load or on reset.

Reset
REQ-035 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, pc=START_DEFAULT (so addressROM=16'h0000), instr=32'h0, instr_pc=16'h0, instr_valid=0, halted=0.
REQ-036 Reset asserted mid-fetch SHALL discard any unconsumed word, with no partial update on the release edge.
REQ-037 Release of rst_n SHALL be registered, with the first state change on the first rising edge after release.

Verification
REQ-038 Streaming: ROM[k]=32'h100+k, HALT_WORD at address 8, start_addr=0, instr_ready=1 -> instr_pc 0..8 on consecutive cycles; halted=1 one cycle after word 8 is consumed; addressROM stays 8.
REQ-039 Backpressure: instr_ready=0 for 3 cycles while word @2 is valid -> instr=32'h102 held, addressROM=3 held; release -> 32'h103 follows on the next cycle with no gap.
REQ-040 Branch: branch_valid=1, target=16'h0040, while word @4 is valid and instr_ready=0 -> instr_valid=0 next cycle; the next valid word has instr_pc=16'h0040.
REQ-041 Wrap: start_addr=16'hFFFE, no halt word -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-042 Async reset: pulse rst_n low for 3 ns, away from clk edges, during streaming -> instr_valid=0 and addressROM=0 immediately; the block stays in IDLE until start.
REQ-043 Restart: in HALT, start=1 with start_addr=16'h0010 -> halted=0 next cycle; the first word valid two edges later with instr_pc=16'h0010.
